// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared state and result encodings for the comparators
package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } cmp_state_t;

  // One-hot result word, ordered {lt, eq, gt}; all-zero means "undecided".
  typedef logic [2:0] cmp_result_t;

  localparam cmp_result_t CMP_NONE = 3'b000;
  localparam cmp_result_t CMP_LT   = 3'b100;
  localparam cmp_result_t CMP_EQ   = 3'b010;
  localparam cmp_result_t CMP_GT   = 3'b001;

  // Decision for one bit position scanned MSB first. At the sign bit a set
  // bit marks the negative (smaller) operand; below it a set bit marks the
  // larger operand. Equal bits leave the comparison undecided.
  function automatic cmp_result_t cmp_bit_decide(
    input logic bit_a,
    input logic bit_b,
    input logic sign_bit
  );
    if (bit_a == bit_b) begin
      return CMP_NONE;
    end
    if (sign_bit) begin
      return bit_a ? CMP_LT : CMP_GT;
    end
    return bit_a ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/comparator_serial_msb.sv
// rtl/comparator_serial_msb.sv - serial MSB-first signed comparator with valid/ready
module comparator_serial_msb
  import comparator_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(N - 1);

  cmp_state_t       state;
  cmp_state_t       next_state;
  logic [N-1:0]     sa;
  logic [N-1:0]     sb;
  logic [CNT_W-1:0] idx;
  cmp_result_t      res;
  cmp_result_t      decision;
  logic             last_bit;

  // Outputs are decoded purely from registered state, so neither i_valid nor
  // o_ready can reach them combinationally.
  assign o_valid      = (state == S_DONE);
  assign {lt, eq, gt} = res;

  // Next-state, handshake decode and the decision for the bit under the scan head.
  always_comb begin
    next_state = state;
    i_ready    = 1'b0;
    busy       = 1'b0;
    decision   = cmp_bit_decide(sa[N-1], sb[N-1], idx == IDX_MSB);
    last_bit   = (idx == '0);
    case (state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if ((decision != CMP_NONE) || last_bit) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (o_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State, operand shift registers, bit index and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      idx   <= '0;
      res   <= CMP_NONE;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            sa  <= a;
            sb  <= b;
            idx <= IDX_MSB;
          end
        end
        S_SCAN: begin
          sa <= sa << 1;
          sb <= sb << 1;
          if (decision != CMP_NONE) begin
            res <= decision;
          end else if (last_bit) begin
            res <= CMP_EQ;
          end else begin
            // Exit at idx==0 happens above, so the index never wraps.
            idx <= idx - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (o_ready) begin
            res <= CMP_NONE;
          end
        end
        default: begin
          res <= CMP_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial_msb.sv
// tb/tb_comparator_serial_msb.sv - directed self-checking bench for comparator_serial_msb
module tb_comparator_serial_msb;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        o_valid;
  logic        o_ready;
  logic        lt;
  logic        eq;
  logic        gt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  comparator_serial_msb #(.N(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .a       (a),
    .b       (b),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .lt      (lt),
    .eq      (eq),
    .gt      (gt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until the accept edge.
  task automatic accept(input logic [31:0] va, input logic [31:0] vb, input string tag);
    int n;
    n = 0;
    while (!i_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_ready"}, {31'b0, i_ready}, 32'd1);
    a       = va;
    b       = vb;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  // Count edges after the accept edge until o_valid rises (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
  endtask

  task automatic run_pair(input logic [31:0] va, input logic [31:0] vb,
                          input logic [2:0] exp_res, input int exp_lat, input string tag);
    int lat;
    accept(va, vb, tag);
    wait_result(lat);
    check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    check({tag, "_res"}, {29'b0, lt, eq, gt}, {29'b0, exp_res});
    check({tag, "_lat"}, lat, exp_lat);
    consume();
    check({tag, "_clr"}, {29'b0, o_valid, i_ready, lt | eq | gt}, {29'b0, 3'b010});
  endtask

  initial begin
    int lat;
    rst     = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    a       = '0;
    b       = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_outs", {27'b0, o_valid, lt, eq, gt, busy}, 32'd0);
    check("rst_iready", {31'b0, i_ready}, 32'd1);

    // Sign bit differs: -1 < 0 in one edge
    run_pair(32'hFFFF_FFFF, 32'h0000_0000, R_LT, 1, "neg1_vs_0");

    // Equal operands scan every bit; busy visible mid-scan
    accept(32'h0000_0005, 32'h0000_0005, "eq5");
    check("eq5_busy", {30'b0, busy, i_ready}, 32'd2);
    wait_result(lat);
    check("eq5_res", {29'b0, lt, eq, gt}, {29'b0, R_EQ});
    check("eq5_lat", lat, 32);
    consume();

    // Differences in the LSB
    run_pair(32'h7FFF_FFFE, 32'h7FFF_FFFF, R_LT, 32, "lsb_lt");
    run_pair(32'h7FFF_FFFF, 32'h7FFF_FFFE, R_GT, 32, "lsb_gt");
    run_pair(32'h8000_0000, 32'h8000_0001, R_LT, 32, "min_lt");

    // Sign differences and an interior bit
    run_pair(32'd100, 32'hFFFF_FF9C, R_GT, 1, "p100_m100");
    run_pair(32'h0000_0100, 32'h0000_0080, R_GT, 24, "bit8");
    run_pair(32'h7FFF_FFFF, 32'h8000_0000, R_GT, 1, "max_min");
    run_pair(32'hFFFF_FFFF, 32'h8000_0000, R_GT, 2, "neg1_min");

    // Backpressure: result held stable, then consume with i_valid already high
    accept(32'h0000_0100, 32'h0000_0080, "bp");
    wait_result(lat);
    check("bp_lat", lat, 24);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", {28'b0, o_valid, lt, eq, gt}, {28'b0, 1'b1, R_GT});
      check("bp_iready", {31'b0, i_ready}, 32'd0);
    end
    a       = 32'd5;
    b       = 32'd9;
    i_valid = 1'b1;
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    check("bp_idle", {28'b0, o_valid, i_ready, busy, lt | eq | gt}, {28'b0, 4'b0100});
    step();
    i_valid = 1'b0;
    check("bp_accept", {30'b0, busy, i_ready}, 32'd2);
    wait_result(lat);
    check("bp2_res", {29'b0, lt, eq, gt}, {29'b0, R_LT});
    check("bp2_lat", lat, 29);
    consume();

    // Reset mid-scan, then a fresh negative pair
    accept(32'h0000_0000, 32'h0000_0000, "mid");
    step();
    step();
    step();
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst", {27'b0, o_valid, i_ready, busy, lt | eq | gt, 1'b0}, {27'b0, 5'b01000});
    run_pair(32'hFFFF_FFF9, 32'hFFFF_FFFD, R_LT, 30, "m7_m3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
